// File: rtl/fetch_if.sv
// Fetch-unit bus bundle: RAM read port, IR valid/ready handshake and redirect request.
interface fetch_if #(
    parameter int unsigned PC_W    = 8,
    parameter int unsigned INSTR_W = 16
);
    logic [PC_W-1:0]    ram_r_addr;
    logic [INSTR_W-1:0] ram_r_data;
    logic [INSTR_W-1:0] ir;
    logic [PC_W-1:0]    ir_pc;
    logic               ir_valid;
    logic               ir_ready;
    logic               redirect_en;
    logic [PC_W-1:0]    redirect_pc;

    modport master (
        output ram_r_addr, ir, ir_pc, ir_valid,
        input  ram_r_data, ir_ready, redirect_en, redirect_pc
    );

    modport slave (
        input  ram_r_addr, ir, ir_pc, ir_valid,
        output ram_r_data, ir_ready, redirect_en, redirect_pc
    );
endinterface

// File: rtl/fetch_unit.sv
// Instruction-fetch front end: owns PC/IR, hides the RAM's one-cycle read latency,
// and presents fetched words over valid/ready with redirect-driven flush.
module fetch_unit #(
    parameter int unsigned PC_W    = 8,
    parameter int unsigned INSTR_W = 16,
    parameter int unsigned CNT_W   = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [PC_W-1:0]  start_pc,
    fetch_if.master          bus,
    output logic [CNT_W-1:0] fetch_count
);
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ADDR = 2'd1,
        S_LOAD = 2'd2,
        S_HOLD = 2'd3
    } state_t;

    state_t             state;
    logic [PC_W-1:0]    pc;
    logic [INSTR_W-1:0] ir_q;
    logic [PC_W-1:0]    ir_pc_q;
    logic               ir_valid_q;

    // RAM address follows the PC directly so the read can start in S_ADDR.
    assign bus.ram_r_addr = pc;
    assign bus.ir         = ir_q;
    assign bus.ir_pc      = ir_pc_q;
    assign bus.ir_valid   = ir_valid_q;

    // Redirect outranks everything except the post-reset start_pc load.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= S_IDLE;
            pc          <= '0;
            ir_q        <= '0;
            ir_pc_q     <= '0;
            ir_valid_q  <= 1'b0;
            fetch_count <= '0;
        end else if (state != S_IDLE && bus.redirect_en) begin
            pc         <= bus.redirect_pc;
            ir_valid_q <= 1'b0;
            state      <= S_ADDR;
        end else begin
            case (state)
                S_IDLE: begin
                    pc    <= start_pc;
                    state <= S_ADDR;
                end
                S_ADDR: begin
                    state <= S_LOAD;
                end
                S_LOAD: begin
                    ir_q       <= bus.ram_r_data;
                    ir_pc_q    <= pc;
                    pc         <= pc + PC_W'(1);
                    ir_valid_q <= 1'b1;
                    state      <= S_HOLD;
                end
                S_HOLD: begin
                    if (bus.ir_ready) begin
                        ir_valid_q  <= 1'b0;
                        fetch_count <= fetch_count + CNT_W'(1);
                        state       <= S_ADDR;
                    end
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end
endmodule
